// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PIC definitions: sequencer state encoding and OCW2 layout.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK1    = 3'd1,
        ST_GAP     = 3'd2,
        ST_ACK2    = 3'd3,
        ST_SERVICE = 3'd4,
        ST_EOI     = 3'd5
    } state_t;

    localparam int PHASE_CNT_W = 4;

    // OCW2 field positions: R, SL, EOI flags and the 3-bit level field.
    localparam int OCW2_R_BIT         = 7;
    localparam int OCW2_SL_BIT        = 6;
    localparam int OCW2_EOI_BIT       = 5;
    localparam int OCW2_LEVEL_MSB     = 2;
    localparam int OCW2_LEVEL_LSB     = 0;

    localparam logic [7:0] OCW2_NONSPEC_EOI = 8'h20;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = D;
        sync_d = meta_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign Q = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - two-pulse INTA acknowledge sequencer with vector capture.
// Define INTA_AUTO_EOI_EN to issue a non-specific EOI write after each service routine.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INT,
    input  logic       EN,
    input  logic [7:0] D,
    input  logic       HANDLER_DONE,
    output logic       INTA,
    output logic [7:0] VECTOR,
    output logic       VECTOR_VALID,
    output logic       BUSY,
    output logic       EOI_WR,
    output logic [7:0] EOI_DATA
);

    localparam logic [PHASE_CNT_W-1:0] LOW_RELOAD = PHASE_CNT_W'(INTA_LOW_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] GAP_RELOAD = PHASE_CNT_W'(INTA_GAP_CYCLES - 1);

    logic int_s;

    state_t                 state_q, state_d;
    logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   inta_q, inta_d;
    logic [7:0]             vector_q, vector_d;
    logic                   vector_valid_q, vector_valid_d;
    logic                   eoi_wr_q, eoi_wr_d;
    logic [7:0]             eoi_data_q, eoi_data_d;

    sync_2ff u_int_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (INT),
        .Q     (int_s)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        eoi_wr_d       = 1'b0;
        eoi_data_d     = 8'h00;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (int_s && EN) begin
                    state_d = ST_ACK1;
                    cnt_d   = LOW_RELOAD;
                end
            end
            ST_ACK1: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK2;
                    cnt_d   = LOW_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK2: begin
                // The PIC drives the vector while the second pulse is low; grab it on the last low cycle.
                if (cnt_q == '0) begin
                    state_d        = ST_SERVICE;
                    cnt_d          = '0;
                    vector_d       = D;
                    vector_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SERVICE: begin
                if (HANDLER_DONE) begin
`ifdef INTA_AUTO_EOI_EN
                    state_d    = ST_EOI;
                    eoi_wr_d   = 1'b1;
                    eoi_data_d = OCW2_NONSPEC_EOI;
`else
                    state_d    = ST_IDLE;
`endif
                end
            end
            ST_EOI: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // INTA is derived from the next state so the pin comes straight off a flop.
        inta_d = !((state_d == ST_ACK1) || (state_d == ST_ACK2));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            inta_q         <= 1'b1;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
            eoi_wr_q       <= 1'b0;
            eoi_data_q     <= 8'h00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            inta_q         <= inta_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            eoi_wr_q       <= eoi_wr_d;
            eoi_data_q     <= eoi_data_d;
        end
    end

    assign INTA         = inta_q;
    assign VECTOR       = vector_q;
    assign VECTOR_VALID = vector_valid_q;
    assign BUSY         = (state_q != ST_IDLE);
    assign EOI_WR       = eoi_wr_q;
    assign EOI_DATA     = eoi_data_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - self-checking bench for inta_sequencer (default and 1/15 timing).
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_in;
    logic       en;
    logic [7:0] d;
    logic       hd;

    logic       inta_a, vv_a, busy_a, eoi_wr_a;
    logic [7:0] vec_a, eoi_data_a;
    logic       inta_b, vv_b, busy_b, eoi_wr_b;
    logic [7:0] vec_b, eoi_data_b;

    logic       sel;
    logic       o_inta, o_vv, o_busy, o_eoi_wr;
    logic [7:0] o_vec, o_eoi_data;

`ifdef INTA_AUTO_EOI_EN
    localparam bit AUTO_EOI = 1'b1;
`else
    localparam bit AUTO_EOI = 1'b0;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         cur_l;
    int         cur_g;
    logic [7:0] exp_prev_vec;

    always #5 clk = ~clk;

    inta_sequencer dut_a (
        .CLK          (clk),
        .RESET        (reset),
        .INT          (int_in),
        .EN           (en),
        .D            (d),
        .HANDLER_DONE (hd),
        .INTA         (inta_a),
        .VECTOR       (vec_a),
        .VECTOR_VALID (vv_a),
        .BUSY         (busy_a),
        .EOI_WR       (eoi_wr_a),
        .EOI_DATA     (eoi_data_a)
    );

    inta_sequencer #(
        .INTA_LOW_CYCLES (1),
        .INTA_GAP_CYCLES (15)
    ) dut_b (
        .CLK          (clk),
        .RESET        (reset),
        .INT          (int_in),
        .EN           (en),
        .D            (d),
        .HANDLER_DONE (hd),
        .INTA         (inta_b),
        .VECTOR       (vec_b),
        .VECTOR_VALID (vv_b),
        .BUSY         (busy_b),
        .EOI_WR       (eoi_wr_b),
        .EOI_DATA     (eoi_data_b)
    );

    assign o_inta     = sel ? inta_b     : inta_a;
    assign o_vv       = sel ? vv_b       : vv_a;
    assign o_busy     = sel ? busy_b     : busy_a;
    assign o_eoi_wr   = sel ? eoi_wr_b   : eoi_wr_a;
    assign o_vec      = sel ? vec_b      : vec_a;
    assign o_eoi_data = sel ? eoi_data_b : eoi_data_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit e_inta, input bit e_busy, input bit e_vv,
                           input logic [7:0] e_vec, input bit e_wr, input logic [7:0] e_data);
        chk({tag, " inta"},     {7'b0, o_inta},   {7'b0, e_inta});
        chk({tag, " busy"},     {7'b0, o_busy},   {7'b0, e_busy});
        chk({tag, " vvalid"},   {7'b0, o_vv},     {7'b0, e_vv});
        chk({tag, " vector"},   o_vec,            e_vec);
        chk({tag, " eoi_wr"},   {7'b0, o_eoi_wr}, {7'b0, e_wr});
        chk({tag, " eoi_data"}, o_eoi_data,       e_data);
    endtask

    task automatic chk_idle(input string tag);
        chk_all(tag, 1'b1, 1'b0, 1'b0, exp_prev_vec, 1'b0, 8'h00);
    endtask

    // Raise INT with EN=1 from a quiet idle; the two synchronizer stages delay ACK1 by two cycles.
    task automatic start_idle();
        int_in = 1'b1;
        en     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle($sformatf("sync_wait%0d", i));
        end
    endtask

    // Precondition: the next edge enters ACK1. Cycle k=1 is the first ACK1 cycle.
    task automatic run_seq(input logic [7:0] vec, input int h, input bit rand_hd,
                           input int mode, input bit cont);
        int s;
        int last;
        bit e_inta;
        bit e_busy;
        bit e_wr;
        s    = 2 * cur_l + cur_g + 1;
        last = s + h + 1 + (AUTO_EOI ? 1 : 0);
        for (int k = 1; k <= last; k++) begin
            tick();
            e_inta = !((k <= cur_l) || ((k >= cur_l + cur_g + 1) && (k <= 2 * cur_l + cur_g)));
            e_busy = (k <= s + h) ? 1'b1 : ((k == s + h + 1) ? AUTO_EOI : 1'b0);
            e_wr   = AUTO_EOI && (k == s + h + 1);
            chk_all($sformatf("seq L%0d k=%0d", cur_l, k), e_inta, e_busy, (k == s),
                    (k >= s) ? vec : exp_prev_vec, e_wr, e_wr ? 8'h20 : 8'h00);

            if (k == s + h)
                hd = 1'b1;
            else if ((k < s) && rand_hd)
                hd = 1'($urandom_range(0, 1));
            else
                hd = 1'b0;
            d = (k == 2 * cur_l + cur_g) ? vec : 8'($urandom);
            if (k >= s - 2) begin
                int_in = cont;
                en     = cont;
            end else if (mode == 1) begin
                int_in = 1'($urandom_range(0, 1));
                en     = 1'($urandom_range(0, 1));
            end else if ((mode == 2) && (k >= cur_l + 1)) begin
                int_in = 1'b0;
            end
        end
        exp_prev_vec = vec;
    endtask

    initial begin
        bit prev_cont;
        bit c;

        reset  = 1'b1;
        int_in = 1'b0;
        en     = 1'b0;
        d      = 8'h00;
        hd     = 1'b0;
        sel    = 1'b0;
        cur_l  = 2;
        cur_g  = 2;
        exp_prev_vec = 8'h00;

        for (int i = 0; i < 3; i++) tick();
        chk_idle("reset_a");
        sel = 1'b1;
        #1;
        chk_idle("reset_b");
        sel = 1'b0;
        reset = 1'b0;
        tick();
        chk_idle("post_reset");

        // Nominal acknowledge, vector 0x48.
        start_idle();
        run_seq(8'h48, 2, 1'b0, 0, 1'b0);

        // EN low blocks acknowledge; raising EN starts ACK1 on the next edge.
        int_in = 1'b1;
        en     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle($sformatf("en_low%0d", i));
        end
        en = 1'b1;
        run_seq(8'($urandom), 0, 1'b1, 0, 1'b1);
        run_seq(8'($urandom), 1, 1'b1, 0, 1'b0);

        // INT withdrawn during GAP: no abort.
        start_idle();
        run_seq(8'h4F, 1, 1'b0, 2, 1'b0);

        // Randomized INT/EN/HANDLER_DONE activity inside sequences.
        prev_cont = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!prev_cont) start_idle();
            c = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            run_seq(8'($urandom), int'($urandom_range(0, 4)), 1'b1, 1, c);
            prev_cont = c;
        end

        // Reset during the second ACK2 cycle.
        start_idle();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_all($sformatf("prerst k=%0d", k),
                    !((k <= cur_l) || (k >= cur_l + cur_g + 1)), 1'b1, 1'b0, exp_prev_vec, 1'b0, 8'h00);
            d = (k >= 5) ? 8'hA5 : 8'($urandom);
            if (k == 6) reset = 1'b1;
        end
        tick();
        exp_prev_vec = 8'h00;
        chk_idle("midack2_reset");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle($sformatf("resync%0d", i));
        end
        tick();
        chk_all("reenter_ack1", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        // Short pulses / long gap instance, back-to-back services.
        reset  = 1'b1;
        int_in = 1'b0;
        en     = 1'b0;
        hd     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sel   = 1'b1;
        cur_l = 1;
        cur_g = 15;
        exp_prev_vec = 8'h00;
        tick();
        chk_idle("b_idle");
        start_idle();
        run_seq(8'($urandom), 3, 1'b1, 0, 1'b1);
        run_seq(8'($urandom), 0, 1'b1, 1, 1'b1);
        run_seq(8'($urandom), 2, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 Parameter INTA_LOW_CYCLES, default 2: cycles INTA is held low per acknowledge pulse (legal range 1..15).
REQ-002 Parameter INTA_GAP_CYCLES, default 2: cycles INTA is held high between the two pulses (legal range 1..15).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 INT  input  1  interrupt request from PIC, asynchronous to CLK.
REQ-006 EN  input  1  CPU interrupt-enable flag; 0 blocks new acknowledge cycles.
REQ-007 D  input  8  data bus from PIC, carries vector during second INTA pulse.
REQ-008 HANDLER_DONE  input  1  one-cycle pulse: service routine finished.
REQ-009 INTA  output  1  active-low interrupt acknowledge to PIC.
REQ-010 VECTOR  output  8  captured interrupt vector, held until next capture.
REQ-011 VECTOR_VALID  output  1  one-cycle pulse when VECTOR updates.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 EOI_WR  output  1  one-cycle OCW2 write strobe to PIC.
REQ-014 EOI_DATA  output  8  OCW2 value presented with EOI_WR.

Function
REQ-015 INT SHALL pass through a 2-flop synchronizer; only the synchronized value (INT_S) is used.
REQ-016 FSM states: IDLE, ACK1, GAP, ACK2, SERVICE, EOI; exactly one active.
REQ-017 IDLE -> ACK1 on the edge where INT_S=1 and EN=1; otherwise remain in IDLE.
REQ-018 ACK1: INTA=0 for exactly INTA_LOW_CYCLES cycles, then -> GAP.
REQ-019 GAP: INTA=1 for exactly INTA_GAP_CYCLES cycles, then -> ACK2.
REQ-020 ACK2: INTA=0 for exactly INTA_LOW_CYCLES cycles; D is sampled into VECTOR on the last ACK2 cycle; then -> SERVICE.
REQ-021 VECTOR_VALID SHALL be 1 for exactly the first SERVICE cycle.
REQ-022 Once ACK1 is entered, the sequence SHALL complete regardless of INT_S or EN changes (no abort).
REQ-023 SERVICE: wait for HANDLER_DONE; HANDLER_DONE in any other state is ignored.
REQ-024 HANDLER_DONE in the same cycle as VECTOR_VALID SHALL be honoured.
REQ-025 INTA SHALL be registered (glitch-free) and 1 in IDLE, GAP, SERVICE, EOI.
REQ-026 A single phase counter, width 4, counts down to 0 for ACK1/GAP/ACK2; it wraps to its reload value on each phase entry.
REQ-027 After SERVICE/EOI, return to IDLE; a still-asserted INT_S with EN=1 re-enters ACK1 one cycle later (no back-to-back without an IDLE cycle).

Reset
REQ-028 RESET=1 at any edge, including mid-pulse: next state IDLE, INTA=1, VECTOR=8'h00, VECTOR_VALID=0, BUSY=0, EOI_WR=0, EOI_DATA=8'h00, counter=0, synchronizer flops=0.

Configuration
REQ-029 Macro INTA_AUTO_EOI_EN defined: SERVICE -> EOI on HANDLER_DONE; EOI lasts one cycle with EOI_WR=1, EOI_DATA=8'h20 (non-specific EOI, R=0 SL=0 EOI=1); then -> IDLE.
REQ-030 Macro undefined: SERVICE -> IDLE on HANDLER_DONE; EOI state unreachable; EOI_WR and EOI_DATA constant 0.

Structure
REQ-031 Shared package pic_pkg SHALL hold the FSM state encoding, OCW2 bit positions (R=7, SL=6, EOI=5, level=2:0) and constant OCW2_NONSPEC_EOI=8'h20.
REQ-032 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, CLK, RESET, D, Q); all else in inta_sequencer.

Verification
REQ-033 Defaults, EN=1, INT rises, D=8'h48 during ACK2 -> INTA low 2 cycles, high 2, low 2; VECTOR=8'h48 with one VECTOR_VALID pulse; BUSY high from ACK1 entry.
REQ-034 EN=0, INT=1 for 20 cycles -> INTA stays 1, BUSY=0; raise EN -> ACK1 entered next edge.
REQ-035 INT drops during GAP, D=8'h4F -> sequence completes, VECTOR=8'h4F.
REQ-036 RESET pulsed during 2nd cycle of ACK2 -> next cycle INTA=1, BUSY=0, VECTOR=8'h00, no VECTOR_VALID.
REQ-037 With INTA_AUTO_EOI_EN, HANDLER_DONE in SERVICE -> next cycle EOI_WR=1, EOI_DATA=8'h20 for one cycle; without macro EOI_WR never 1.
REQ-038 INTA_LOW_CYCLES=1, INTA_GAP_CYCLES=15, INT held high across two services -> each pulse exactly 1 cycle, gap 15, one IDLE cycle between sequences.
